s382_phase_sequencer: RTL
=========================

// Module: s382_phase_sequencer
// PURPOSE
//  Sequential traffic-light phase sequencer that produces the C3_Q phase counter and UC interval timer.
//  The combinational next-state cones in the s382 family consume these signals.
//  Drives the two-road light outputs.
//  Sits at top of the s382 controller datapath; downstream cones read C3_Q/UC_* and light outputs.
// PARAMETERS
//  GRN_TIME   30  green interval in ticks (road 1 and road 2), range 2..159
//  YLW_TIME    5  yellow interval in ticks, range 1..159
//  ARED_TIME   2  all-red interval in ticks, range 1..159
// PORTS
//  CK      in   1  clock, rising edge
//  CLR     in   1  asynchronous active-high reset
//  EN      in   1  tick enable; timer and phase advance only when 1
//  FM      in   1  fast mode: green interval becomes GRN_TIME/2 (floor, min 1)
//  TESTL   in   1  active-low test: when 0 every phase interval is 1 tick
//  C3_Q    out  4  phase counter (0..5 legal)
//  UC_LO   out  4  timer low digit, BCD 0..9
//  UC_HI   out  4  timer high digit, 0..15
//  PHASE_DONE out 1 one-cycle pulse, the cycle after a phase expires
//  GRN1,YLW1,RED1  out 1 each  road-1 lights
//  GRN2,YLW2,RED2  out 1 each  road-2 lights
// BEHAVIOUR
//  Reset (CLR=1, async, dominates everything): C3_Q=0, UC_LO=0, UC_HI=0, PHASE_DONE=0.
//   Lights decode to GRN1=1, RED2=1, all others 0.
//  Phases (C3_Q): 0 G1/R2, 1 Y1/R2, 2 R1/R2, 3 R1/G2, 4 R1/Y2, 5 R1/R2; 5 wraps to 0.
//  Lights are a combinational Moore decode of registered C3_Q; exactly one light per road is high.
//  Timer value T = 10*UC_HI + UC_LO.
//   Enabled tick: UC_LO increments; UC_LO 9->0 carries into UC_HI.
//  Interval I(phase): phases 0 and 3 use GRN_TIME, or FM ? max(1,GRN_TIME/2) : GRN_TIME.
//   Phases 1 and 4 use YLW_TIME; phases 2 and 5 use ARED_TIME. TESTL=0 forces I=1.
//  Expiry: EN=1 and T >= I-1. Next cycle: T=0, C3_Q=next phase, PHASE_DONE=1.
//   Each phase therefore lasts exactly I enabled ticks.
//  EN=0: C3_Q and UC_* hold; PHASE_DONE=0.
//  FM or TESTL change mid-phase takes effect on the same cycle.
//   If T already >= new I-1, expiry occurs on the next enabled tick (no underflow, no wrap through 159).
//  UC_HI saturation: T never exceeds 158 under legal parameters; parameters out of range are a synthesis-time error.
//  Illegal C3_Q (6..15, fault injection only): all six lights 0 except RED1=RED2=1.
//   On the next clock, independent of EN: C3_Q=0, T=0, PHASE_DONE=0.
//  CLR asserted mid-phase: immediate return to reset values.
//   After release, the first enabled tick counts as tick 1 of phase 0.
// STRUCTURE
//  Package s382_pkg holds:
//   - phase localparams PH_G1..PH_AR2 (4-bit)
//   - 6-bit light-vector constants per phase
//   - the interval-select function
//  Sub-module s382_bcd_timer holds UC_LO/UC_HI:
//   - ports: CK, CLR, EN, CLR_T (sync clear), I (8-bit)
//   - outputs: UC_LO, UC_HI, EXPIRE
//  Top holds the C3_Q register, PHASE_DONE flop and light decode.
// TESTING
//  1. Reset default params, EN=1, FM=0, TESTL=1.
//     -> C3_Q=0 for 30 cycles, then 1 for 5, 2 for 2, 3 for 30, 4 for 5, 5 for 2, then 0.
//     -> PHASE_DONE pulses 6 times per 74-cycle loop.
//  2. In phase 0 at T=10, raise FM -> C3_Q=1 after 15 total enabled ticks.
//     Raise FM at T=20 instead -> advance on the very next enabled tick.
//  3. TESTL=0, EN=1 -> C3_Q steps 0,1,2,3,4,5,0 on consecutive cycles; UC_LO/UC_HI stay 0; PHASE_DONE held 1.
//  4. EN toggling 1,0,1,0 -> phase 0 lasts 60 cycles.
//     -> UC_LO sequence 9->0 with UC_HI 0->1 observed at T=10.
//  5. Assert CLR asynchronously mid-phase 4 at T=3 -> outputs to reset values before next CK edge.
//     -> After release, GRN1=1 and RED2=1, and phase 0 lasts 30 ticks.
//  6. Force C3_Q=4'hA -> RED1=RED2=1, others 0; next edge C3_Q=0, UC=0 with EN=0.

Source files
------------

// File: rtl/s382_phase_sequencer_pkg.sv
// Shared phase encodings, light patterns and interval selection for the s382 sequencer.
package s382_pkg;

    localparam int unsigned PH_W  = 4;
    localparam int unsigned T_W   = 8;
    localparam int unsigned LT_W  = 6;

    // Phase encodings carried on C3_Q
    localparam logic [PH_W-1:0] PH_G1  = 4'd0;
    localparam logic [PH_W-1:0] PH_Y1  = 4'd1;
    localparam logic [PH_W-1:0] PH_AR1 = 4'd2;
    localparam logic [PH_W-1:0] PH_G2  = 4'd3;
    localparam logic [PH_W-1:0] PH_Y2  = 4'd4;
    localparam logic [PH_W-1:0] PH_AR2 = 4'd5;

    // Light vectors, bit order {GRN1, YLW1, RED1, GRN2, YLW2, RED2}
    localparam logic [LT_W-1:0] LT_G1  = 6'b100_001;
    localparam logic [LT_W-1:0] LT_Y1  = 6'b010_001;
    localparam logic [LT_W-1:0] LT_AR  = 6'b001_001;
    localparam logic [LT_W-1:0] LT_G2  = 6'b001_100;
    localparam logic [LT_W-1:0] LT_Y2  = 6'b001_010;
    localparam logic [LT_W-1:0] LT_ILL = 6'b001_001;

    // Interval length in ticks for the given phase and mode inputs
    function automatic logic [T_W-1:0] interval_sel(
        input logic [PH_W-1:0] ph,
        input logic            fm,
        input logic            testl,
        input int unsigned     grn,
        input int unsigned     ylw,
        input int unsigned     ared
    );
        int unsigned     g;
        logic [T_W-1:0]  ival;
        g = grn / 2;
        if (fm == 1'b0) begin
            g = grn;
        end else if (g == 0) begin
            g = 1;
        end
        case (ph)
            PH_G1, PH_G2:   ival = T_W'(g);
            PH_Y1, PH_Y2:   ival = T_W'(ylw);
            PH_AR1, PH_AR2: ival = T_W'(ared);
            default:        ival = 8'd1;
        endcase
        if (testl == 1'b0) begin
            ival = 8'd1;
        end
        return ival;
    endfunction

    // Successor phase in the six-phase ring
    function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] ph);
        return (ph == PH_AR2) ? PH_G1 : ph + 4'd1;
    endfunction

    // Moore light decode; unknown phases show all-red on both roads
    function automatic logic [LT_W-1:0] light_vec(input logic [PH_W-1:0] ph);
        logic [LT_W-1:0] lv;
        case (ph)
            PH_G1:          lv = LT_G1;
            PH_Y1:          lv = LT_Y1;
            PH_AR1, PH_AR2: lv = LT_AR;
            PH_G2:          lv = LT_G2;
            PH_Y2:          lv = LT_Y2;
            default:        lv = LT_ILL;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/s382_phase_sequencer_if.sv
// Control inputs and observable state of the phase sequencer.
interface s382_phase_sequencer_if;
    logic       EN;
    logic       FM;
    logic       TESTL;
    logic [3:0] C3_Q;
    logic [3:0] UC_LO;
    logic [3:0] UC_HI;
    logic       PHASE_DONE;
    logic       GRN1;
    logic       YLW1;
    logic       RED1;
    logic       GRN2;
    logic       YLW2;
    logic       RED2;

    modport master (
        output EN, FM, TESTL,
        input  C3_Q, UC_LO, UC_HI, PHASE_DONE,
        input  GRN1, YLW1, RED1, GRN2, YLW2, RED2
    );

    modport slave (
        input  EN, FM, TESTL,
        output C3_Q, UC_LO, UC_HI, PHASE_DONE,
        output GRN1, YLW1, RED1, GRN2, YLW2, RED2
    );
endinterface

// File: rtl/s382_phase_sequencer_bcd_timer.sv
// Two-digit interval timer: BCD low digit, binary high digit, expiry compare.
module s382_bcd_timer
    import s382_pkg::*;
(
    input  logic           CK,
    input  logic           CLR,
    input  logic           EN,
    input  logic           CLR_T,
    input  logic [T_W-1:0] I,
    output logic [3:0]     UC_LO,
    output logic [3:0]     UC_HI,
    output logic           EXPIRE
);

    logic [T_W-1:0] t_val;

    // Binary view of the timer for the expiry compare
    assign t_val  = (T_W'(UC_HI) * 8'd10) + T_W'(UC_LO);
    // Expiry uses >= so a shortened interval never underflows or wraps
    assign EXPIRE = EN & ~CLR_T & (t_val >= (I - 8'd1));

    // Digit registers: clear on fault/expiry, count on enabled ticks
    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            UC_LO <= 4'd0;
            UC_HI <= 4'd0;
        end else if (CLR_T || EXPIRE) begin
            UC_LO <= 4'd0;
            UC_HI <= 4'd0;
        end else if (EN) begin
            if (UC_LO == 4'd9) begin
                UC_LO <= 4'd0;
                UC_HI <= UC_HI + 4'd1;
            end else begin
                UC_LO <= UC_LO + 4'd1;
            end
        end
    end

endmodule

// File: rtl/s382_phase_sequencer.sv
// Traffic-light phase sequencer: phase register, interval timer and light decode.
module s382_phase_sequencer
    import s382_pkg::*;
#(
    parameter int unsigned GRN_TIME  = 30,
    parameter int unsigned YLW_TIME  = 5,
    parameter int unsigned ARED_TIME = 2
) (
    input  logic                   CK,
    input  logic                   CLR,
    s382_phase_sequencer_if.slave  bus
);

    // Intervals above 159 would overflow the two-digit timer
    if (GRN_TIME < 2 || GRN_TIME > 159) begin : g_bad_grn
        $error("GRN_TIME out of range 2..159");
    end
    if (YLW_TIME < 1 || YLW_TIME > 159) begin : g_bad_ylw
        $error("YLW_TIME out of range 1..159");
    end
    if (ARED_TIME < 1 || ARED_TIME > 159) begin : g_bad_ared
        $error("ARED_TIME out of range 1..159");
    end

    logic [PH_W-1:0] c3_q;
    logic [PH_W-1:0] c3_d;
    logic            done_q;
    logic            done_d;
    logic            illegal;
    logic            expire;
    logic [T_W-1:0]  ival;
    logic [LT_W-1:0] lights;

    assign illegal = (c3_q > PH_AR2);
    assign ival    = interval_sel(c3_q, bus.FM, bus.TESTL, GRN_TIME, YLW_TIME, ARED_TIME);

    s382_bcd_timer u_timer (
        .CK     (CK),
        .CLR    (CLR),
        .EN     (bus.EN),
        .CLR_T  (illegal),
        .I      (ival),
        .UC_LO  (bus.UC_LO),
        .UC_HI  (bus.UC_HI),
        .EXPIRE (expire)
    );

    // Phase register and phase-done pulse flop
    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            c3_q   <= PH_G1;
            done_q <= 1'b0;
        end else begin
            c3_q   <= c3_d;
            done_q <= done_d;
        end
    end

    // Next phase: recover from illegal codes, else advance on expiry
    always_comb begin
        c3_d   = c3_q;
        done_d = 1'b0;
        if (illegal) begin
            c3_d = PH_G1;
        end else if (expire) begin
            c3_d   = next_phase(c3_q);
            done_d = 1'b1;
        end
    end

    // Light decode from the registered phase
    always_comb begin
        lights = LT_ILL;
        lights = light_vec(c3_q);
    end

    assign bus.C3_Q       = c3_q;
    assign bus.PHASE_DONE = done_q;
    assign bus.GRN1       = lights[5];
    assign bus.YLW1       = lights[4];
    assign bus.RED1       = lights[3];
    assign bus.GRN2       = lights[2];
    assign bus.YLW2       = lights[1];
    assign bus.RED2       = lights[0];

endmodule
